formatter: RTL and testbench
============================

FORMATTER -- requirements
Module: formatter

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port f2a_id_req_o, output, 1 bit: one-cycle request for the arbiter to register a new channel id.
REQ-004 SHALL have port a2f_id_i, input, 2 bits: granted channel; 2'b11 = no channel requesting.
REQ-005 SHALL have port a2f_val_i, input, 1 bit: selected slave data valid.
REQ-006 SHALL have port a2f_data_i, input, 32 bits: selected slave data word.
REQ-007 SHALL have port a2f_pkglen_sel_i, input, 3 bits: selected slave packet-length code.
REQ-008 SHALL have port f2a_ack_o, output, 1 bit: word accepted; routed by the arbiter to the selected slave.
REQ-009 SHALL have port fmt_req_o, output, 1 bit: packet ready, requesting the downstream link.
REQ-010 SHALL have port fmt_grant_i, input, 1 bit: downstream accepts the packet.
REQ-011 SHALL have port fmt_chid_o, output, 2 bits: channel id of the packet.
REQ-012 SHALL have port fmt_length_o, output, 6 bits: packet word count.
REQ-013 SHALL have port fmt_start_o, output, 1 bit: first-word strobe.
REQ-014 SHALL have port fmt_end_o, output, 1 bit: last-word strobe.
REQ-015 SHALL have port fmt_data_o, output, 32 bits: packet data word.

Function
REQ-016 SHALL implement an FSM with states IDLE, REQ_ID, WAIT_ID, COLLECT, SEND_REQ and SEND.
REQ-017 SHALL move from IDLE to REQ_ID unconditionally on the next cycle.
REQ-018 SHALL assert f2a_id_req_o for exactly one cycle in REQ_ID, then go to WAIT_ID.
REQ-019 SHALL sample a2f_id_i in WAIT_ID; if it is 2'b11 it SHALL return to IDLE (retry poll), otherwise it SHALL latch the id and go to COLLECT.
REQ-020 SHALL latch the packet length from a2f_pkglen_sel_i in WAIT_ID: 0->4, 1->8, 2->16, 3->32, 4..7->32 words.
REQ-021 SHALL drive f2a_ack_o combinationally as (state==COLLECT) && a2f_val_i.
REQ-022 SHALL, on each cycle where a2f_val_i && f2a_ack_o, write a2f_data_i into a 32x32 buffer at the word counter and increment the counter.
REQ-023 SHALL leave COLLECT for SEND_REQ in the cycle after the last word is accepted; f2a_ack_o SHALL be 0 from then on.
REQ-024 SHALL hold COLLECT indefinitely while a2f_val_i is low (gaps allowed), without timeout.
REQ-025 SHALL, in SEND_REQ, hold fmt_req_o=1 and present fmt_chid_o and fmt_length_o stable until fmt_grant_i is sampled high.
REQ-026 SHALL enter SEND on the cycle after the grant and deassert fmt_req_o at that cycle.
REQ-027 SHALL, in SEND, emit one buffered word per cycle, registered, in write order.
REQ-028 SHALL assert fmt_start_o with word 0 and fmt_end_o with the last word; both SHALL be high together only if length is 1, which cannot occur.
REQ-029 SHALL return to IDLE after the fmt_end_o cycle; the next packet needs at least 3 cycles (IDLE, REQ_ID, WAIT_ID) before COLLECT.
REQ-030 SHALL ignore fmt_grant_i outside SEND_REQ.
REQ-031 SHALL ignore a2f_val_i outside COLLECT.
REQ-032 SHALL keep fmt_data_o at 0 outside SEND.
REQ-033 SHALL use 6-bit word counters that never exceed the latched length.

Reset
REQ-034 SHALL, when rst_i is high at a clock edge, go to IDLE and clear all counters, fmt_req_o, fmt_start_o, fmt_end_o, f2a_id_req_o, fmt_data_o, fmt_chid_o and fmt_length_o to 0; f2a_ack_o is then 0 by REQ-021.
REQ-035 SHALL, on reset mid-packet (COLLECT, SEND_REQ or SEND), abandon the packet; buffer contents are don't-care, and no start or end strobe appears afterwards for that packet.

Verification
REQ-036 SHALL verify: arbiter id=1, pkglen_sel=0, val continuous with data 0x100..0x103 -> exactly 4 acks; then fmt_req=1, chid=1, length=4; after grant, data 0x100..0x103 with start on 0x100 and end on 0x103.
REQ-037 SHALL verify: a2f_id=2'b11 in WAIT_ID -> FSM returns to IDLE, f2a_id_req_o re-pulses 2 cycles later, and f2a_ack_o is never asserted.
REQ-038 SHALL verify: pkglen_sel=6 with val toggling every other cycle -> 32 words collected over about 64 cycles with no acks when val is low; fmt_length_o=32.
REQ-039 SHALL verify: grant withheld for 10 cycles -> fmt_req_o, fmt_chid_o and fmt_length_o stay stable and no fmt_start_o appears until the cycle after grant.
REQ-040 SHALL verify: rst_i asserted after 3 of 8 words collected -> next cycle all outputs are 0 and the state is IDLE; a following full packet is transferred correctly.
REQ-041 SHALL verify: grant pulsed during COLLECT -> ignored, with no early SEND.

Source files
------------

// File: rtl/formatter_if.sv
// Arbiter-side and downstream-link signals of the packet formatter.
// master = formatter view, slave = arbiter/link view.
interface formatter_if;
  logic        f2a_id_req_o;
  logic [1:0]  a2f_id_i;
  logic        a2f_val_i;
  logic [31:0] a2f_data_i;
  logic [2:0]  a2f_pkglen_sel_i;
  logic        f2a_ack_o;
  logic        fmt_req_o;
  logic        fmt_grant_i;
  logic [1:0]  fmt_chid_o;
  logic [5:0]  fmt_length_o;
  logic        fmt_start_o;
  logic        fmt_end_o;
  logic [31:0] fmt_data_o;

  modport master (
    output f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_start_o, fmt_end_o, fmt_data_o,
    input  a2f_id_i, a2f_val_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );

  modport slave (
    input  f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_start_o, fmt_end_o, fmt_data_o,
    output a2f_id_i, a2f_val_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );
endinterface

// File: rtl/formatter.sv
// Packet formatter: obtains a channel id from the arbiter, buffers one packet
// of 4..32 words from the selected slave, then streams it to the downstream link.
module formatter (
  input  logic        clk_i,
  input  logic        rst_i,
  formatter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_ID   = 3'd1,
    WAIT_ID  = 3'd2,
    COLLECT  = 3'd3,
    SEND_REQ = 3'd4,
    SEND     = 3'd5
  } state_e;

  state_e      state_r;
  logic [5:0]  len_r;
  logic [5:0]  wr_cnt_r;
  logic [5:0]  rd_cnt_r;
  logic [1:0]  chid_r;
  logic        id_req_r;
  logic        req_r;
  logic        start_r;
  logic        end_r;
  logic [31:0] data_r;
  logic [31:0] buf_r [32];
  logic        ack_s;
  logic        last_wr_s;

  function automatic logic [5:0] decode_len(input logic [2:0] sel);
    case (sel)
      3'd0:    decode_len = 6'd4;
      3'd1:    decode_len = 6'd8;
      3'd2:    decode_len = 6'd16;
      default: decode_len = 6'd32;
    endcase
  endfunction

  // Word acceptance is combinational so the slave sees ack in the cycle it offers val.
  always_comb begin
    ack_s     = 1'b0;
    last_wr_s = 1'b0;
    if (state_r == COLLECT) begin
      ack_s     = bus.a2f_val_i;
      last_wr_s = bus.a2f_val_i && (wr_cnt_r == (len_r - 6'd1));
    end else begin
      ack_s     = 1'b0;
      last_wr_s = 1'b0;
    end
  end

  // Packet buffer write port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (ack_s) begin
      buf_r[wr_cnt_r[4:0]] <= bus.a2f_data_i;
    end
  end

  // Control FSM with all link-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      len_r    <= 6'd0;
      wr_cnt_r <= 6'd0;
      rd_cnt_r <= 6'd0;
      chid_r   <= 2'd0;
      id_req_r <= 1'b0;
      req_r    <= 1'b0;
      start_r  <= 1'b0;
      end_r    <= 1'b0;
      data_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          id_req_r <= 1'b1;
          state_r  <= REQ_ID;
        end
        REQ_ID: begin
          id_req_r <= 1'b0;
          state_r  <= WAIT_ID;
        end
        WAIT_ID: begin
          if (bus.a2f_id_i == 2'b11) begin
            state_r <= IDLE;
          end else begin
            chid_r   <= bus.a2f_id_i;
            len_r    <= decode_len(bus.a2f_pkglen_sel_i);
            wr_cnt_r <= 6'd0;
            state_r  <= COLLECT;
          end
        end
        COLLECT: begin
          if (ack_s) begin
            wr_cnt_r <= wr_cnt_r + 6'd1;
            if (last_wr_s) begin
              req_r   <= 1'b1;
              state_r <= SEND_REQ;
            end
          end
        end
        SEND_REQ: begin
          if (bus.fmt_grant_i) begin
            req_r    <= 1'b0;
            start_r  <= 1'b1;
            end_r    <= (len_r == 6'd1);
            data_r   <= buf_r[5'd0];
            rd_cnt_r <= 6'd1;
            state_r  <= SEND;
          end
        end
        SEND: begin
          // The word just presented was the last one: drop strobes and data together.
          if (end_r) begin
            start_r  <= 1'b0;
            end_r    <= 1'b0;
            data_r   <= 32'd0;
            rd_cnt_r <= 6'd0;
            state_r  <= IDLE;
          end else begin
            start_r  <= 1'b0;
            end_r    <= (rd_cnt_r == (len_r - 6'd1));
            data_r   <= buf_r[rd_cnt_r[4:0]];
            rd_cnt_r <= rd_cnt_r + 6'd1;
          end
        end
        default: begin
          id_req_r <= 1'b0;
          req_r    <= 1'b0;
          start_r  <= 1'b0;
          end_r    <= 1'b0;
          data_r   <= 32'd0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.f2a_id_req_o = id_req_r;
  assign bus.f2a_ack_o    = ack_s;
  assign bus.fmt_req_o    = req_r;
  assign bus.fmt_chid_o   = chid_r;
  assign bus.fmt_length_o = len_r;
  assign bus.fmt_start_o  = start_r;
  assign bus.fmt_end_o    = end_r;
  assign bus.fmt_data_o   = data_r;

endmodule

// File: tb/tb_formatter.sv
// Scoreboard bench for formatter: a driver plays arbiter/slave, a grant process
// plays the link, and a monitor checks every emitted packet against queued expectations.
module tb_formatter;

  logic clk_i = 1'b0;
  logic rst_i;

  formatter_if bus ();

  formatter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_data_q[$];
  int          exp_chid_q[$];
  int          exp_len_q[$];
  int          pkts_done   = 0;
  int          grant_delay = 0;
  bit          hung        = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    hung = 1'b1;
    $display("FAIL timeout_%s: awaited event not seen within budget at %0t", name, $time);
  endtask

  // Packet length as a plain rule: codes 0..2 double from 4, everything above is 32.
  function automatic int ref_len(input int sel);
    return (sel >= 3) ? 32 : (4 << sel);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},    32'(bus.f2a_ack_o),    32'd0);
    chk({tag, "_id_req"}, 32'(bus.f2a_id_req_o), 32'd0);
    chk({tag, "_req"},    32'(bus.fmt_req_o),    32'd0);
    chk({tag, "_chid"},   32'(bus.fmt_chid_o),   32'd0);
    chk({tag, "_length"}, 32'(bus.fmt_length_o), 32'd0);
    chk({tag, "_start"},  32'(bus.fmt_start_o),  32'd0);
    chk({tag, "_end"},    32'(bus.fmt_end_o),    32'd0);
    chk({tag, "_data"},   bus.fmt_data_o,        32'd0);
  endtask

  // Downstream link: grant after grant_delay request cycles, random noise otherwise.
  initial begin : link_model
    int wait_cnt;
    wait_cnt = 0;
    bus.fmt_grant_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.fmt_req_o) begin
        if (wait_cnt >= grant_delay) begin
          bus.fmt_grant_i = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.fmt_grant_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        bus.fmt_grant_i = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: checks request header, then each streamed word against the scoreboard.
  initial begin : monitor
    int          idx;
    int          cur_len;
    int          cur_chid;
    bit          in_pkt;
    bit          prev_req;
    logic [31:0] ew;
    idx = 0; cur_len = 0; cur_chid = 0; in_pkt = 1'b0; prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_pkt   = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (in_pkt) begin
          ew = 32'hDEAD_BEEF;
          if (exp_data_q.size() > 0) ew = exp_data_q.pop_front();
          chk("fmt_data",        bus.fmt_data_o,            ew);
          chk("fmt_start",       32'(bus.fmt_start_o),      32'(idx == 0));
          chk("fmt_end",         32'(bus.fmt_end_o),        32'(idx == cur_len - 1));
          chk("fmt_req_in_send", 32'(bus.fmt_req_o),        32'd0);
          idx++;
          if (idx >= cur_len) begin
            in_pkt = 1'b0;
            pkts_done++;
          end
        end else begin
          chk("fmt_start_outside", 32'(bus.fmt_start_o), 32'd0);
          chk("fmt_end_outside",   32'(bus.fmt_end_o),   32'd0);
          chk("fmt_data_outside",  bus.fmt_data_o,       32'd0);
        end
        if (bus.fmt_req_o) begin
          if (!prev_req) begin
            chk("hdr_queue_nonempty", 32'(exp_chid_q.size() != 0), 32'd1);
            if (exp_chid_q.size() != 0) begin
              cur_chid = exp_chid_q.pop_front();
              cur_len  = exp_len_q.pop_front();
            end
          end
          chk("fmt_chid",   32'(bus.fmt_chid_o),   32'(cur_chid));
          chk("fmt_length", 32'(bus.fmt_length_o), 32'(cur_len));
          if (bus.fmt_grant_i) begin
            in_pkt = 1'b1;
            idx    = 0;
          end
        end
        prev_req = bus.fmt_req_o;
      end
    end
  end

  // One packet from the arbiter/slave side. mode: 0 continuous val, 1 alternating, 2 random.
  task automatic run_packet(input logic [1:0] id, input logic [2:0] sel, input int mode,
                            input int gdelay, input int retries, input bit rand_data,
                            input logic [31:0] base, input int abort_at);
    int          len;
    int          idx;
    int          k;
    int          budget;
    int          target;
    bit          found;
    bit          v;
    logic [31:0] w[$];
    if (hung) return;
    len = ref_len(int'(sel));
    idx = 0; k = 0; budget = 0; found = 1'b0;
    grant_delay = gdelay;
    for (int i = 0; i < len; i++) w.push_back(rand_data ? $urandom : base + 32'(i));

    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk_i);
      found = bus.f2a_id_req_o;
    end
    if (!found) begin timeout("id_req"); return; end

    // "No channel" answer: the poll repeats, REQ_ID pulse 2 cycles after the WAIT_ID sample.
    for (int r = 0; r < retries; r++) begin
      @(posedge clk_i); #1;
      bus.a2f_id_i = 2'b11; bus.a2f_val_i = 1'b1; bus.a2f_data_i = $urandom;
      @(negedge clk_i);
      chk("ack_retry_wait", 32'(bus.f2a_ack_o), 32'd0);
      chk("id_req_low_wait", 32'(bus.f2a_id_req_o), 32'd0);
      @(negedge clk_i);
      chk("ack_retry_idle", 32'(bus.f2a_ack_o), 32'd0);
      chk("id_req_low_idle", 32'(bus.f2a_id_req_o), 32'd0);
      @(negedge clk_i);
      chk("id_req_repulse", 32'(bus.f2a_id_req_o), 32'd1);
    end

    @(posedge clk_i); #1;
    bus.a2f_id_i = id; bus.a2f_pkglen_sel_i = sel;
    bus.a2f_val_i = 1'b1; bus.a2f_data_i = $urandom;
    @(negedge clk_i);
    chk("ack_wait_id", 32'(bus.f2a_ack_o), 32'd0);

    while (idx < len && !(abort_at >= 0 && idx == abort_at)) begin
      @(posedge clk_i); #1;
      bus.a2f_id_i = 2'b11;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 2 == 0);
      else                v = ($urandom_range(0, 2) != 0);
      bus.a2f_val_i = v; bus.a2f_data_i = w[idx];
      k++;
      @(negedge clk_i);
      chk("ack", 32'(bus.f2a_ack_o), 32'(v));
      if (v && bus.f2a_ack_o) idx++;
      budget++;
      if (budget > 500) begin timeout("collect"); return; end
    end

    if (idx < len) begin
      @(posedge clk_i); #1;
      rst_i = 1'b1; bus.a2f_val_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0; bus.a2f_val_i = 1'b1;
      @(negedge clk_i);
      check_all_zero("after_reset");
      @(negedge clk_i);
      chk("idle_after_reset", 32'(bus.f2a_id_req_o), 32'd1);
      bus.a2f_val_i = 1'b0;
      return;
    end

    foreach (w[i]) exp_data_q.push_back(w[i]);
    exp_chid_q.push_back(int'(id));
    exp_len_q.push_back(len);
    target = pkts_done + 1;
    budget = 0;
    while (pkts_done < target) begin
      @(posedge clk_i); #1;
      bus.a2f_val_i = 1'($urandom_range(0, 1)); bus.a2f_data_i = $urandom;
      @(negedge clk_i);
      chk("ack_after_last", 32'(bus.f2a_ack_o), 32'd0);
      budget++;
      if (budget > 300) begin timeout("packet_out"); return; end
    end
    bus.a2f_val_i = 1'b0;
  endtask

  initial begin : stimulus
    rst_i = 1'b1;
    bus.a2f_id_i = 2'b11; bus.a2f_val_i = 1'b1; bus.a2f_data_i = 32'd0;
    bus.a2f_pkglen_sel_i = 3'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0; bus.a2f_val_i = 1'b0;

    run_packet(2'd1, 3'd0, 0, 0,  0, 1'b0, 32'h100, -1);
    run_packet(2'd2, 3'd1, 0, 1,  1, 1'b1, 32'd0,   -1);
    run_packet(2'd0, 3'd6, 1, 0,  0, 1'b1, 32'd0,   -1);
    run_packet(2'd2, 3'd2, 2, 10, 0, 1'b1, 32'd0,   -1);
    run_packet(2'd1, 3'd1, 0, 0,  0, 1'b1, 32'd0,    3);
    run_packet(2'd1, 3'd1, 0, 2,  0, 1'b1, 32'd0,   -1);
    for (int p = 0; p < 20; p++) begin
      run_packet(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 2)), 1'b1, 32'd0, -1);
    end

    repeat (4) @(negedge clk_i);
    chk("scoreboard_drained", 32'(exp_data_q.size() + exp_chid_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
